// File: rtl/spmv_row_sequencer_if.sv
// spmv_row_sequencer_if
// Bus bundle between the CSR row sequencer and its neighbours.
//   nz_rd / nz_addr        : nonzero-memory read strobe and 0-based index
//   mac_en / mac_clr       : MAC accumulate enable, clr loads instead of adds
//   row_vld / row_rdy      : row-result handshake (sequencer -> downstream)
//   row_idx / row_zero     : index of the current row, and "row is empty"
// master = sequencer side, slave = memory/MAC/result-consumer side.
interface spmv_row_sequencer_if #(
  parameter int N_ROWS = 16,
  parameter int PTR_W  = 8
);
  localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

  logic             nz_rd;
  logic [PTR_W-1:0] nz_addr;
  logic             mac_en;
  logic             mac_clr;
  logic             row_vld;
  logic             row_rdy;
  logic [ROW_W-1:0] row_idx;
  logic             row_zero;

  modport master (
    output nz_rd, nz_addr, mac_en, mac_clr, row_vld, row_idx, row_zero,
    input  row_rdy
  );

  modport slave (
    input  nz_rd, nz_addr, mac_en, mac_clr, row_vld, row_idx, row_zero,
    output row_rdy
  );
endinterface

// File: rtl/spmv_row_sequencer.sv
// spmv_row_sequencer
// Walks a CSR sparse matrix row by row. A start pulse in IDLE latches the
// row-pointer vector; each nonempty row issues one nonzero read per cycle,
// the MAC strobes follow one cycle later, and each row ends with a
// row-result handshake.
// Ports:
//   i_clk, i_rstn   : clock, asynchronous active-low reset
//   i_start         : start pulse, only honoured in IDLE
//   i_row_ptr       : N_ROWS+1 packed row pointers, entry i at [i*PTR_W +: PTR_W]
//   o_busy          : high from accepted start until o_done
//   o_done          : one-cycle pulse after the last row handshake
//   o_err           : sticky, some row had ptr[i+1] < ptr[i]
//   bus (master)    : nonzero read, MAC strobes and row-result handshake
// Build option:
//   SPMV_SEQ_SKIP_EMPTY_EN : empty rows produce no row result and are
//                            stepped over directly from ROW.
module spmv_row_sequencer #(
  parameter int N_ROWS = 16,
  parameter int PTR_W  = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic                        i_start,
  input  logic [(N_ROWS+1)*PTR_W-1:0] i_row_ptr,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_err,
  spmv_row_sequencer_if.master        bus
);
  localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int IDX_W = $clog2(N_ROWS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ROW, S_FETCH, S_WAIT, S_EMIT, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] ptr_q [0:N_ROWS];
  logic [PTR_W-1:0] ptr_d [0:N_ROWS];
  logic [ROW_W-1:0] row_q, row_d;
  logic [PTR_W-1:0] k_q, k_d;
  logic             first_q, first_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic             mac_en_q, mac_en_d;
  logic             mac_clr_q, mac_clr_d;

  logic [PTR_W-1:0] lo, hi;
  logic             last_row;
  logic             nz_rd;
  logic             row_vld;

  // Bounds of the current row come straight from the latched pointer table.
  assign lo       = ptr_q[IDX_W'(row_q)];
  assign hi       = ptr_q[IDX_W'(row_q) + IDX_W'(1)];
  assign last_row = (row_q == ROW_W'(N_ROWS - 1));

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= S_IDLE;
      for (int i = 0; i <= N_ROWS; i++) ptr_q[i] <= '0;
      row_q     <= '0;
      k_q       <= '0;
      first_q   <= 1'b0;
      zero_q    <= 1'b0;
      err_q     <= 1'b0;
      mac_en_q  <= 1'b0;
      mac_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      for (int i = 0; i <= N_ROWS; i++) ptr_q[i] <= ptr_d[i];
      row_q     <= row_d;
      k_q       <= k_d;
      first_q   <= first_d;
      zero_q    <= zero_d;
      err_q     <= err_d;
      mac_en_q  <= mac_en_d;
      mac_clr_q <= mac_clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    for (int i = 0; i <= N_ROWS; i++) ptr_d[i] = ptr_q[i];
    row_d   = row_q;
    k_d     = k_q;
    first_d = first_q;
    zero_d  = zero_q;
    err_d   = err_q;
    nz_rd   = 1'b0;
    row_vld = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          for (int i = 0; i <= N_ROWS; i++) ptr_d[i] = i_row_ptr[i*PTR_W +: PTR_W];
          row_d   = '0;
          err_d   = 1'b0;
          state_d = S_ROW;
        end
      end
      S_ROW: begin
        o_busy = 1'b1;
        if (hi > lo) begin
          k_d     = lo;
          first_d = 1'b1;
          zero_d  = 1'b0;
          state_d = S_FETCH;
        end else begin
          if (hi < lo) err_d = 1'b1;
`ifdef SPMV_SEQ_SKIP_EMPTY_EN
          zero_d = 1'b0;
          if (last_row) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + ROW_W'(1);
            state_d = S_ROW;
          end
`else
          zero_d  = 1'b1;
          state_d = S_EMIT;
`endif
        end
      end
      S_FETCH: begin
        // hi > lo is guaranteed here, so hi-1 cannot underflow.
        o_busy  = 1'b1;
        nz_rd   = 1'b1;
        first_d = 1'b0;
        if (k_q == hi - PTR_W'(1)) state_d = S_WAIT;
        else                       k_d     = k_q + PTR_W'(1);
      end
      S_WAIT: begin
        o_busy  = 1'b1;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        o_busy  = 1'b1;
        row_vld = 1'b1;
        if (bus.row_rdy) begin
          if (last_row) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + ROW_W'(1);
            state_d = S_ROW;
          end
        end
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // MAC strobes trail the read by one cycle so they line up with read data.
  assign mac_en_d  = nz_rd;
  assign mac_clr_d = nz_rd & first_q;

  assign bus.nz_rd    = nz_rd;
  assign bus.nz_addr  = nz_rd ? k_q : '0;
  assign bus.mac_en   = mac_en_q;
  assign bus.mac_clr  = mac_clr_q;
  assign bus.row_vld  = row_vld;
  assign bus.row_idx  = row_vld ? row_q : '0;
  assign bus.row_zero = row_vld & zero_q;
  assign o_err        = err_q;
endmodule
